gate_tester: RTL and testbench
==============================

# gate_tester

Self-checking stimulus/response block for the combinational gate experiment: it drives the 4-bit gate input vector, sweeps all 16 combinations, samples the seven gate outputs after a settle window and compares them with a built-in golden model. It sits on the other side of the gate block's pins, between the board's start key and the result LEDs/segment display, and turns the truth-table check into a single start/done run.

## Interface
- `SETTLE`, default 2: wait cycles between applying a vector and sampling outputs (0 allowed).
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; sampled only in IDLE, begins a sweep.
- `in_vec`  out  4  vector driven to the gate block's `in[3:0]`.
- `dut_out`  in  7  gate outputs: [0] and, [1] or, [2] not, [3] nand, [4] aoi, [5] xor_1, [6] xor_2.
- `busy`  out  1  high while a sweep runs.
- `done`  out  1  one-cycle pulse at end of sweep.
- `pass`  out  1  high when last sweep had zero mismatches; held until next start.
- `err_count`  out  5  number of failing vectors, 0..16.
- `fail_mask`  out  7  OR of per-output mismatch bits over the sweep.
- `first_fail`  out  4  first failing vector; 0 if none.

## Operation
- Golden model, v = in_vec: and = v[1]&v[0]; or = v[1]|v[0]; not = ~v[0]; nand = ~(v[1]&v[0]); aoi = ~((v[3]&v[2])|(v[1]&v[0])); xor_1 = xor_2 = v[1]^v[0].
- States: IDLE → APPLY → WAIT → CHECK → (APPLY | DONE) → IDLE.
- IDLE: `start`=1 clears `err_count`, `fail_mask`, `first_fail`, `pass`; sets `in_vec`=0; → APPLY.
- APPLY: one cycle; loads settle counter with `SETTLE`; → WAIT, or → CHECK when `SETTLE`=0.
- WAIT: decrements counter; → CHECK when it reaches 1.
- CHECK: mismatch = `dut_out` ^ golden. If nonzero: `err_count`+1, `fail_mask` |= mismatch, `first_fail` = `in_vec` if this is the first failure. If `in_vec`=15 → DONE, else `in_vec`+1 → APPLY.
- DONE: one cycle; `done`=1, `pass` = (`err_count`==0, including the final CHECK result); `in_vec` returns to 0; → IDLE.
- `start` outside IDLE is ignored; `start` held high in IDLE after DONE launches a new sweep.
- Counter width is sized from `SETTLE`; `in_vec` never wraps mid-sweep (15 is terminal).
- Reset, at any time including mid-sweep: state IDLE, all outputs 0.

## Timing
- Reset values: `in_vec`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_mask`=0, `first_fail`=0.
- All outputs are registered; `dut_out` is sampled on the clock edge that ends CHECK.
- Per vector: SETTLE+2 cycles (APPLY, SETTLE×WAIT, CHECK). Sweep: 16·(SETTLE+2) cycles.
- With `start` sampled at edge E: `busy` is high from E to E+16·(SETTLE+2). `done` is high for exactly the one cycle after that. With SETTLE=2, `done` is high 64 edges after E.
- Result outputs are stable from `done` until the next accepted `start`.

## Structure
- Shared package `gate_pkg`:
  - state enum.
  - output-index constants AND_I..XOR2_I (0..6).
  - `NUM_VEC`=16.
- Sub-module `gate_golden`: purely combinational, 4-bit vector in → 7-bit expected out. It is reused by other experiment benches.
- FSM, settle counter and result registers live in `gate_tester`.

## Test plan
- Correct gate block connected, SETTLE=2, pulse `start`:
  - `done` 64 cycles later.
  - `pass`=1, `err_count`=0, `fail_mask`=0, `first_fail`=0.
- `dut_out[6]` stuck at 0:
  - `err_count`=8.
  - `fail_mask`=7'b1000000.
  - `first_fail`=4'd1.
  - `pass`=0.
- `dut_out[4]` inverted:
  - `err_count`=16.
  - `fail_mask`=7'b0010000.
  - `first_fail`=0.
  - `pass`=0.
- `start` pulsed again at cycle 20 of a sweep:
  - ignored; single `done` at cycle 64.
  - `in_vec` sequence 0..15 unbroken.
- `rst_n` low at cycle 30 of a sweep:
  - all outputs 0 immediately (async).
  - next `start` runs a full clean 64-cycle sweep.
- SETTLE=0 with correct gate block:
  - `done` 32 cycles after `start`.
  - `pass`=1.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared types and constants for the combinational gate experiment.
// The tester, the golden model and the experiment benches all import this.
package gate_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam int AND_I  = 0;
    localparam int OR_I   = 1;
    localparam int NOT_I  = 2;
    localparam int NAND_I = 3;
    localparam int AOI_I  = 4;
    localparam int XOR1_I = 5;
    localparam int XOR2_I = 6;

    localparam int NUM_OUT = 7;
    localparam int NUM_VEC = 16;

    localparam logic [3:0] LAST_VEC = 4'(NUM_VEC - 1);

endpackage

// File: rtl/gate_golden.sv
// Golden model of the gate block: 4-bit input vector to the seven expected outputs.
// Purely combinational so other experiment benches can reuse it as-is.
module gate_golden
    import gate_pkg::*;
(
    input  logic [3:0]         i_vec,
    output logic [NUM_OUT-1:0] o_expected
);

    always_comb begin
        o_expected         = '0;
        o_expected[AND_I]  = i_vec[1] & i_vec[0];
        o_expected[OR_I]   = i_vec[1] | i_vec[0];
        o_expected[NOT_I]  = ~i_vec[0];
        o_expected[NAND_I] = ~(i_vec[1] & i_vec[0]);
        o_expected[AOI_I]  = ~((i_vec[3] & i_vec[2]) | (i_vec[1] & i_vec[0]));
        o_expected[XOR1_I] = i_vec[1] ^ i_vec[0];
        o_expected[XOR2_I] = i_vec[1] ^ i_vec[0];
    end

endmodule

// File: rtl/gate_tester.sv
// Sweeps all 16 input vectors into the gate block, waits SETTLE cycles per vector,
// and compares the sampled outputs against gate_golden, accumulating a result summary.
module gate_tester
    import gate_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [3:0]         in_vec,
    input  logic [NUM_OUT-1:0] dut_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [4:0]         err_count,
    output logic [NUM_OUT-1:0] fail_mask,
    output logic [3:0]         first_fail
);

    localparam int              CNT_W     = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [3:0]           r_in_vec;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [4:0]           r_err_count;
    logic [NUM_OUT-1:0]   r_fail_mask;
    logic [3:0]           r_first_fail;
    logic [NUM_OUT-1:0]   w_expected;
    logic [NUM_OUT-1:0]   w_mismatch;
    logic                 w_fail;

    gate_golden u_golden (
        .i_vec      (r_in_vec),
        .o_expected (w_expected)
    );

    assign w_mismatch = dut_out ^ w_expected;
    assign w_fail     = |w_mismatch;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_APPLY;
            ST_APPLY: w_next = (SETTLE == 0) ? ST_CHECK : ST_WAIT;
            ST_WAIT:  if (r_cnt == CNT_W'(1)) w_next = ST_CHECK;
            ST_CHECK: w_next = (r_in_vec == LAST_VEC) ? ST_DONE : ST_APPLY;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Flags are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_in_vec     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_fail_mask  <= '0;
            r_first_fail <= '0;
        end else begin
            r_busy <= (w_next == ST_APPLY) || (w_next == ST_WAIT) || (w_next == ST_CHECK);
            r_done <= (w_next == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_in_vec     <= '0;
                        r_pass       <= 1'b0;
                        r_err_count  <= '0;
                        r_fail_mask  <= '0;
                        r_first_fail <= '0;
                    end
                end
                ST_APPLY: r_cnt <= SETTLE_LD;
                ST_WAIT:  r_cnt <= r_cnt - CNT_W'(1);
                ST_CHECK: begin
                    if (w_fail) begin
                        r_err_count <= r_err_count + 5'd1;
                        r_fail_mask <= r_fail_mask | w_mismatch;
                        if (r_err_count == '0) r_first_fail <= r_in_vec;
                    end
                    if (r_in_vec == LAST_VEC) begin
                        r_in_vec <= '0;
                        r_pass   <= (r_err_count == '0) && !w_fail;
                    end else begin
                        r_in_vec <= r_in_vec + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_vec     = r_in_vec;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err_count;
    assign fail_mask  = r_fail_mask;
    assign first_fail = r_first_fail;

endmodule

// File: tb/tb_gate_tester.sv
// Bench for gate_tester: a fault-injectable gate block model drives dut_out, and a
// scoreboard of expected sweep summaries is checked whenever done pulses.
module tb_gate_tester;

    localparam int TB_SETTLE = 2;
    localparam int PER       = TB_SETTLE + 2;
    localparam int SWEEP     = 16 * PER;

    typedef struct {
        int done_cyc;
        int pass;
        int err;
        int mask;
        int first;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   fault_mode = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] in_vec;
    logic [6:0] dut_out;
    logic       busy, done, pass;
    logic [4:0] err_count;
    logic [6:0] fail_mask;
    logic [3:0] first_fail;

    logic       start0 = 1'b0;
    logic [3:0] in_vec0;
    logic [6:0] dut_out0;
    logic       busy0, done0, pass0;
    logic [4:0] err_count0;
    logic [6:0] fail_mask0;
    logic [3:0] first_fail0;

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_gate(input logic [3:0] v);
        int a, b, s;
        logic [6:0] r;
        a = int'(v[0]);
        b = int'(v[1]);
        s = a + b;
        r[0] = (s == 2);
        r[1] = (s != 0);
        r[2] = (a == 0);
        r[3] = (s != 2);
        r[4] = !((s == 2) || (v[2] && v[3]));
        r[5] = (s == 1);
        r[6] = (s == 1);
        return r;
    endfunction

    function automatic logic [6:0] faulty(input logic [6:0] g, input int f);
        logic [6:0] o;
        o = g;
        if (f == 1) o[6] = 1'b0;
        if (f == 2) o[4] = ~g[4];
        return o;
    endfunction

    function automatic exp_t model_sweep(input int f, input int settle);
        exp_t e;
        logic [6:0] g, mm;
        e.err = 0; e.mask = 0; e.first = 0;
        for (int v = 0; v < 16; v++) begin
            g  = ref_gate(4'(v));
            mm = faulty(g, f) ^ g;
            if (mm != 0) begin
                if (e.err == 0) e.first = v;
                e.err++;
                e.mask = e.mask | int'(mm);
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        e.done_cyc = 16 * (settle + 2);
        return e;
    endfunction

    always_comb dut_out  = faulty(ref_gate(in_vec), fault_mode);
    always_comb dut_out0 = ref_gate(in_vec0);

    gate_tester #(.SETTLE(TB_SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_vec(in_vec), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_mask(fail_mask), .first_fail(first_fail)
    );

    gate_tester #(.SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .in_vec(in_vec0), .dut_out(dut_out0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0),
        .fail_mask(fail_mask0), .first_fail(first_fail0)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic score(input string tag, input int k, input int p, input int e,
                         input int m, input int f);
        exp_t x;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
            return;
        end
        x = sb_q.pop_front();
        check({tag, "_done_cyc"}, k, x.done_cyc);
        check({tag, "_pass"}, p, x.pass);
        check({tag, "_err_count"}, e, x.err);
        check({tag, "_fail_mask"}, m, x.mask);
        check({tag, "_first_fail"}, f, x.first);
    endtask

    task automatic run_sweep(input string tag, input int f, input bit restart20, input bit reset30);
        int k;
        bit seen;
        fault_mode = f;
        if (!reset30) sb_q.push_back(model_sweep(f, TB_SETTLE));
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        seen = 0;
        check({tag, "_busy_k0"}, busy, 1);
        check({tag, "_in_vec_k0"}, in_vec, 0);
        while (!seen && k < 200) begin
            @(posedge clk);
            #1;
            k++;
            if (done) begin
                seen = 1;
            end else if (k < SWEEP) begin
                check({tag, "_busy"}, busy, 1);
                check({tag, "_in_vec"}, in_vec, k / PER);
            end
            start = restart20 && (k == 20);
            if (reset30 && k == 30) begin
                rst_n = 1'b0;
                #1;
                check({tag, "_rst_in_vec"}, in_vec, 0);
                check({tag, "_rst_busy"}, busy, 0);
                check({tag, "_rst_done"}, done, 0);
                check({tag, "_rst_pass"}, pass, 0);
                check({tag, "_rst_err_count"}, err_count, 0);
                check({tag, "_rst_fail_mask"}, fail_mask, 0);
                check({tag, "_rst_first_fail"}, first_fail, 0);
                @(negedge clk) rst_n = 1'b1;
                return;
            end
        end
        if (!seen) begin
            check({tag, "_done_timeout"}, 0, 1);
            void'(sb_q.pop_front());
            return;
        end
        score(tag, k, int'(pass), int'(err_count), int'(fail_mask), int'(first_fail));
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_in_vec_at_done"}, in_vec, 0);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_pass_held"}, pass, sb_q.size() == 0 ? int'(pass) : 0);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int k;
        exp_t e0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_vec", in_vec, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_pass", pass, 0);
        check("reset_err_count", err_count, 0);
        check("reset_fail_mask", fail_mask, 0);
        check("reset_first_fail", first_fail, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_sweep("clean", 0, 1'b0, 1'b0);
        run_sweep("xor2_stuck0", 1, 1'b0, 1'b0);
        run_sweep("aoi_inverted", 2, 1'b0, 1'b0);
        run_sweep("restart_ignored", 0, 1'b1, 1'b0);
        run_sweep("mid_reset", 1, 1'b0, 1'b1);
        run_sweep("after_reset", 0, 1'b0, 1'b0);

        e0 = model_sweep(0, 0);
        sb_q.push_back(e0);
        @(negedge clk) start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        check("settle0_busy_k0", busy0, 1);
        k = 0;
        while (!done0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!done0) begin
            check("settle0_done_timeout", 0, 1);
            void'(sb_q.pop_front());
        end else begin
            score("settle0", k, int'(pass0), int'(err_count0), int'(fail_mask0), int'(first_fail0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
